// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states and coin/gap constants for the cola vending controller
package vend_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;
  localparam int HALF_UNITS = 1;
  localparam int ONE_UNITS = 2;
  localparam int GAP_W = 4;
endpackage

// File: rtl/vend_change_tx.sv
// vend_change_tx: loads a count and emits it as po_money pulses (1 high, CHG_GAP low); done when drained
module vend_change_tx import vend_pkg::*; #(
  parameter int CW = 3,
  parameter int CHG_GAP = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          load,
  input  logic [CW-1:0] count,
  output logic          po_money,
  output logic          done
);
  localparam logic [GAP_W-1:0] GAP = GAP_W'(CHG_GAP);
  logic [CW-1:0] rem;
  logic [GAP_W-1:0] gap;
  assign done = rem == '0 && gap == '0;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      po_money <= 1'b0;
      rem <= '0;
      gap <= '0;
    end else if (load) begin
      po_money <= count != '0;
      rem <= count != '0 ? count - CW'(1) : '0;
      gap <= count != '0 ? GAP : '0;
    end else if (rem != '0 && gap == '0) begin
      po_money <= 1'b1;
      rem <= rem - CW'(1);
      gap <= GAP;
    end else begin
      po_money <= 1'b0;
      gap <= gap != '0 ? gap - GAP_W'(1) : '0;
    end
endmodule

// File: rtl/vend_cola_param.sv
// vend_cola_param: parametrised cola vending FSM with change/refund pulse train; VEND_SALES_CNT_EN adds a saturating sales counter
module vend_cola_param import vend_pkg::*; #(
  parameter int PRICE = 5,
  parameter int CHG_GAP = 1,
  localparam int CW = $clog2(PRICE + 3)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pi_money_half,
  input  logic          pi_money_one,
  input  logic          pi_cancel,
`ifdef VEND_SALES_CNT_EN
  input  logic          pi_cnt_clr,
  output logic [15:0]   po_sales_cnt,
`endif
  output logic          po_cola,
  output logic          po_money,
  output logic          po_reject,
  output logic          po_busy,
  output logic [CW-1:0] po_credit
);
  localparam logic [CW-1:0] PRICE_U = CW'(PRICE);
  state_t state, state_n;
  logic [CW-1:0] chg, chg_n, credit_n, coin, sum, load_cnt;
  logic load, cola_n, reject_n, done;
  assign coin = (pi_money_half ? CW'(HALF_UNITS) : '0) + (pi_money_one ? CW'(ONE_UNITS) : '0);
  assign sum = po_credit + coin;
  vend_change_tx #(.CW(CW), .CHG_GAP(CHG_GAP)) u_tx (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .load(load),
    .count(load_cnt),
    .po_money(po_money),
    .done(done)
  );
  always_comb begin
    state_n = state;
    credit_n = po_credit;
    chg_n = chg;
    load = 1'b0;
    load_cnt = po_credit;
    cola_n = 1'b0;
    reject_n = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (pi_cancel && po_credit != '0) begin
          state_n = REFUND;
          load = 1'b1;
          reject_n = coin != '0;
        end else if (sum >= PRICE_U) begin
          state_n = VEND;
          chg_n = sum - PRICE_U;
          credit_n = '0;
          cola_n = 1'b1;
        end else if (coin != '0) begin
          state_n = COLLECT;
          credit_n = sum;
        end
      end
      VEND: begin
        reject_n = coin != '0;
        load = chg != '0;
        load_cnt = chg;
        state_n = chg != '0 ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_n = coin != '0;
        state_n = done ? IDLE : CHANGE;
      end
      REFUND: begin
        reject_n = coin != '0;
        credit_n = po_money ? po_credit - CW'(1) : po_credit;
        state_n = done ? IDLE : REFUND;
      end
      default: begin
        state_n = IDLE;
        credit_n = '0;
      end
    endcase
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      po_credit <= '0;
      chg <= '0;
      po_cola <= 1'b0;
      po_reject <= 1'b0;
      po_busy <= 1'b0;
    end else begin
      state <= state_n;
      po_credit <= credit_n;
      chg <= chg_n;
      po_cola <= cola_n;
      po_reject <= reject_n;
      po_busy <= state_n inside {VEND, CHANGE, REFUND};
    end
`ifdef VEND_SALES_CNT_EN
  always_ff @(posedge sys_clk)
    if (sys_rst || pi_cnt_clr) po_sales_cnt <= '0;
    else if (po_cola && po_sales_cnt != 16'hFFFF) po_sales_cnt <= po_sales_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vend_cola_param.sv
// tb_vend_cola_param: directed self-checking bench for vend_cola_param at PRICE=5, CHG_GAP=1
module tb_vend_cola_param;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic half = 1'b0;
  logic one = 1'b0;
  logic cancel = 1'b0;
  logic po_cola, po_money, po_reject, po_busy;
  logic [2:0] po_credit;
  int total = 0;
  int bad = 0;
`ifdef VEND_SALES_CNT_EN
  logic cnt_clr = 1'b0;
  logic [15:0] po_sales_cnt;
`endif
  vend_cola_param #(.PRICE(5), .CHG_GAP(1)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .pi_money_half(half),
    .pi_money_one(one),
    .pi_cancel(cancel),
`ifdef VEND_SALES_CNT_EN
    .pi_cnt_clr(cnt_clr),
    .po_sales_cnt(po_sales_cnt),
`endif
    .po_cola(po_cola),
    .po_money(po_money),
    .po_reject(po_reject),
    .po_busy(po_busy),
    .po_credit(po_credit)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic c, input logic m, input logic r, input logic b, input logic [2:0] cr);
    chk({tag, ".cola"}, 16'(po_cola), 16'(c));
    chk({tag, ".money"}, 16'(po_money), 16'(m));
    chk({tag, ".reject"}, 16'(po_reject), 16'(r));
    chk({tag, ".busy"}, 16'(po_busy), 16'(b));
    chk({tag, ".credit"}, 16'(po_credit), 16'(cr));
  endtask
  initial begin
    tick();
    tick();
    chk_out("rst", 0, 0, 0, 0, 0);
    sys_rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      half = 1'b1;
      tick();
      chk("t1.credit", 16'(po_credit), 16'(i));
      chk("t1.cola", 16'(po_cola), 16'd0);
    end
    tick();
    half = 1'b0;
    chk_out("t1.vend", 1, 0, 0, 1, 0);
    tick();
    chk_out("t1.idle", 0, 0, 0, 0, 0);
    tick();
    chk_out("t1.quiet", 0, 0, 0, 0, 0);
`ifdef VEND_SALES_CNT_EN
    chk("t1.sales", po_sales_cnt, 16'd1);
`endif
    one = 1'b1;
    tick();
    chk("t2.c2", 16'(po_credit), 16'd2);
    tick();
    chk("t2.c4", 16'(po_credit), 16'd4);
    tick();
    one = 1'b0;
    chk_out("t2.vend", 1, 0, 0, 1, 0);
    tick();
    chk_out("t2.chg", 0, 1, 0, 1, 0);
    tick();
    chk_out("t2.gap", 0, 0, 0, 1, 0);
    tick();
    chk_out("t2.idle", 0, 0, 0, 0, 0);
    half = 1'b1;
    tick();
    half = 1'b0;
    one = 1'b1;
    tick();
    one = 1'b0;
    chk("t3.c3", 16'(po_credit), 16'd3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_out("t3.p1", 0, 1, 0, 1, 3);
    tick();
    chk_out("t3.g1", 0, 0, 0, 1, 2);
    tick();
    chk_out("t3.p2", 0, 1, 0, 1, 2);
    tick();
    chk_out("t3.g2", 0, 0, 0, 1, 1);
    tick();
    chk_out("t3.p3", 0, 1, 0, 1, 1);
    tick();
    chk_out("t3.g3", 0, 0, 0, 1, 0);
    tick();
    chk_out("t3.idle", 0, 0, 0, 0, 0);
    one = 1'b1;
    tick();
    tick();
    chk("t4.c4", 16'(po_credit), 16'd4);
    half = 1'b1;
    tick();
    half = 1'b0;
    one = 1'b0;
    chk_out("t4.vend", 1, 0, 0, 1, 0);
    tick();
    chk_out("t4.p1", 0, 1, 0, 1, 0);
    tick();
    chk_out("t4.g1", 0, 0, 0, 1, 0);
    tick();
    chk_out("t4.p2", 0, 1, 0, 1, 0);
    tick();
    chk_out("t4.g2", 0, 0, 0, 1, 0);
    tick();
    chk_out("t4.idle", 0, 0, 0, 0, 0);
    one = 1'b1;
    tick();
    tick();
    tick();
    one = 1'b0;
    chk_out("t5.vend", 1, 0, 0, 1, 0);
    tick();
    chk_out("t5.p1", 0, 1, 0, 1, 0);
    one = 1'b1;
    tick();
    one = 1'b0;
    chk_out("t5.rej", 0, 0, 1, 1, 0);
    tick();
    chk_out("t5.idle", 0, 0, 0, 0, 0);
    tick();
    chk_out("t5.quiet", 0, 0, 0, 0, 0);
    one = 1'b1;
    tick();
    one = 1'b0;
    chk("t5.c2", 16'(po_credit), 16'd2);
    cancel = 1'b1;
    half = 1'b1;
    tick();
    cancel = 1'b0;
    half = 1'b0;
    chk_out("t5.r1", 0, 1, 1, 1, 2);
    tick();
    chk_out("t5.rg1", 0, 0, 0, 1, 1);
    tick();
    chk_out("t5.r2", 0, 1, 0, 1, 1);
    tick();
    chk_out("t5.rg2", 0, 0, 0, 1, 0);
    tick();
    chk_out("t5.ridle", 0, 0, 0, 0, 0);
    one = 1'b1;
    tick();
    tick();
    one = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_out("t6.p1", 0, 1, 0, 1, 4);
    tick();
    chk_out("t6.g1", 0, 0, 0, 1, 3);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk_out("t6.rst", 0, 0, 0, 0, 0);
`ifdef VEND_SALES_CNT_EN
    chk("t6.sales", po_sales_cnt, 16'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t6.after", 0, 0, 0, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_cola_param.md
Name: vend_cola_param

Overview:
- Parametrised next-generation cola vending controller.
- Accumulates half-yuan and one-yuan coins into a credit register and vends one cola when credit reaches a configurable price.
- Returns change, or a full refund on cancel, as a serial train of half-yuan pulses.
- Rejects coins inserted while it is busy; sits between the coin acceptor front-end and the dispense/return actuators.

Parameters:
- PRICE, 5, cola price in half-yuan units; legal range 2..15.
- CHG_GAP, 1, number of low cycles between consecutive po_money pulses; legal range 0..15.
- CW, derived = clog2(PRICE+3), width of the credit register; holds up to PRICE+2.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- pi_money_half  in  1  one-cycle pulse; adds 1 unit (0.5 yuan).
- pi_money_one  in  1  one-cycle pulse; adds 2 units (1 yuan).
- pi_cancel  in  1  one-cycle pulse; refunds all credit.
- po_cola  out  1  one-cycle dispense pulse.
- po_money  out  1  one-cycle pulse; each pulse returns 0.5 yuan.
- po_reject  out  1  one-cycle pulse; the coin sampled in the previous cycle was refused and is returned mechanically.
- po_busy  out  1  high in VEND, CHANGE and REFUND.
- po_credit  out  CW  current credit in units.

Behaviour:
- All outputs are registered. On reset every output is 0, credit is 0 and state is IDLE. Reset wins over any other input in the same cycle.
- coin_val = pi_money_half + 2*pi_money_one. If both inputs are high in the same cycle, coin_val = 3 and both coins are accepted.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- IDLE / COLLECT:
  - pi_cancel with credit > 0 -> REFUND, with refund count = credit. A coin in the same cycle is rejected (po_reject next cycle).
  - pi_cancel with credit = 0 is a no-op.
  - Otherwise sum = credit + coin_val.
  - If sum >= PRICE -> VEND, with change = sum - PRICE and credit cleared.
  - Else if coin_val > 0 -> COLLECT, with credit = sum.
  - State is IDLE exactly when credit = 0.
- VEND: po_cola is high for exactly the one cycle after the completing coin's sampling edge. Then -> CHANGE if change > 0, else -> IDLE.
- CHANGE / REFUND:
  - Emit the pending count as po_money pulses: 1 cycle high, then CHG_GAP cycles low, repeated.
  - The first pulse comes in the cycle after entry.
  - After the last pulse plus its gap -> IDLE.
- po_credit counts down with each refund pulse; it is 0 during CHANGE.
- Any coin sampled while busy is ignored for credit and produces po_reject on the next cycle. pi_cancel while busy is ignored.
- Latency examples:
  - Completing coin at edge N -> po_cola in cycle N+1.
  - With CHG_GAP = 1, change pulses fall in cycles N+2, N+4, ...
- Maximum change is 2 units (credit PRICE-1 plus a 3-unit coin pair); maximum refund is PRICE-1 units. The counter width covers both.
- Unknown or illegal state encodings -> IDLE with credit cleared.

Optional Feature:
- Macro VEND_SALES_CNT_EN.
- Defined:
  - Adds output po_sales_cnt [15:0], which increments on every po_cola pulse and saturates at 16'hFFFF.
  - Adds input pi_cnt_clr; it clears the counter synchronously and has priority over an increment in the same cycle.
  - The counter is cleared by sys_rst.
- Undefined: the ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, CHANGE, REFUND);
  - coin unit constants HALF_UNITS = 1 and ONE_UNITS = 2;
  - the gap-counter width constant.
- Sub-module vend_change_tx: a load/count/gap-timer pulse generator.
  - Inputs: load, count, CHG_GAP.
  - Outputs: po_money and done.
  - Shared by the CHANGE and REFUND paths.

Test Plan (PRICE=5, CHG_GAP=1):
- Five pi_money_half pulses on consecutive cycles -> po_cola once, in the cycle after the 5th coin; no po_money; returns to IDLE.
- Three pi_money_one pulses -> credit 2, 4, then vend -> po_cola, then exactly 1 po_money pulse the cycle after; po_credit = 0.
- half, one, then pi_cancel -> REFUND with 3 po_money pulses spaced 2 cycles apart; po_busy high throughout; po_credit steps 3, 2, 1, 0.
- Credit 4, then both coin inputs high in the same cycle -> po_cola, then 2 change pulses.
- pi_money_one during CHANGE -> po_reject next cycle; change count and credit unaffected. pi_cancel plus a coin in the same cycle at credit 2 -> coin rejected and 2 refund pulses.
- sys_rst asserted mid-REFUND -> next cycle all outputs 0, state IDLE, no further po_money pulses; with VEND_SALES_CNT_EN, po_sales_cnt = 0.
